pcpi_issuer: RTL and testbench

CPU-side initiator for the PCPI co-processor interface. Accepts one instruction with its operands on a valid/ready request port and drives `pcpi_valid`, `pcpi_insn`, `pcpi_rs1` and `pcpi_rs2` to attached responders such as the multiplier. It waits for `pcpi_ready` or declares a timeout trap, then returns the result on a valid/ready response port. It sits between the execute stage and the PCPI bus, one transaction in flight.

---
 rtl/pcpi_pkg.sv | 15 +
 rtl/pcpi_timeout_ctr.sv | 34 +++
 rtl/pcpi_issuer.sv | 119 +++++++++++
 tb/tb_pcpi_issuer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpi_pkg.sv
// Shared definitions for the PCPI initiator and its responders:
// issuer state encoding, RV32M decode constants and the default trap timeout.
package pcpi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } pcpi_state_e;

    localparam logic [6:0] PCPI_OPCODE_OP       = 7'b0110011;
    localparam logic [6:0] PCPI_FUNCT7_MULDIV   = 7'b0000001;
    localparam int         PCPI_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/pcpi_timeout_ctr.sv
// Down-counter that flags an unclaimed PCPI instruction after TIMEOUT idle
// ISSUE cycles; TIMEOUT=0 turns it into a counter that never expires.
module pcpi_timeout_ctr
    import pcpi_pkg::*;
#(
    parameter int TIMEOUT = PCPI_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  logic dec,
    output logic expired
);

    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (dec && (TIMEOUT != 0) && (count != '0)) begin
            count <= count - ONE;
        end
    end

    // Expiry is judged on the value present at the edge that would consume it.
    assign expired = (TIMEOUT != 0) && dec && !load && (count == ONE);

endmodule

// File: rtl/pcpi_issuer.sv
// CPU-side PCPI initiator: takes one instruction on a valid/ready request port,
// drives it onto the PCPI bus, and returns the result or a timeout trap.
module pcpi_issuer
    import pcpi_pkg::*;
#(
    parameter int TIMEOUT = PCPI_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_wr,
    output logic        rsp_trap,

    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready
);

    pcpi_state_e state, state_next;
    logic        issue_q;
    logic        accept;
    logic        ctr_load;
    logic        ctr_dec;
    logic        ctr_expired;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = (state == IDLE) && req_valid;

    // Dropping valid in the ready cycle keeps a responder from decoding the same insn twice.
    assign pcpi_valid = issue_q && !pcpi_ready;

    assign ctr_load = accept || ((state == ISSUE) && !pcpi_ready && pcpi_wait);
    assign ctr_dec  = (state == ISSUE) && !pcpi_ready && !pcpi_wait;

    pcpi_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .resetn  (resetn),
        .load    (ctr_load),
        .dec     (ctr_dec),
        .expired (ctr_expired)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            issue_q <= 1'b0;
        end else begin
            state   <= state_next;
            issue_q <= (state_next == ISSUE);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (pcpi_ready || ctr_expired) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A ready in the same cycle as expiry wins: the trap branch is only the fallback.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pcpi_insn <= '0;
            pcpi_rs1  <= '0;
            pcpi_rs2  <= '0;
            rsp_data  <= '0;
            rsp_wr    <= 1'b0;
            rsp_trap  <= 1'b0;
        end else begin
            if (accept) begin
                pcpi_insn <= req_insn;
                pcpi_rs1  <= req_rs1;
                pcpi_rs2  <= req_rs2;
            end
            if ((state == ISSUE) && pcpi_ready) begin
                rsp_data <= pcpi_wr ? pcpi_rd : 32'd0;
                rsp_wr   <= pcpi_wr;
                rsp_trap <= 1'b0;
            end else if (ctr_expired) begin
                rsp_data <= 32'd0;
                rsp_wr   <= 1'b0;
                rsp_trap <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pcpi_issuer.sv
// Scoreboard bench for pcpi_issuer with a behavioural PCPI multiplier responder
// plus a second instance built with the timeout disabled.
`timescale 1ns/1ps
module tb_pcpi_issuer;
    import pcpi_pkg::*;

    localparam logic [31:0] INSN_MUL   = 32'h0220_8033;
    localparam logic [31:0] INSN_MULHU = 32'h0220_B033;
    localparam int BFM_NONE = 0;
    localparam int BFM_MUL  = 1;
    localparam int BFM_HOLD = 2;
    localparam int BFM_DROP = 3;

    typedef struct packed {
        logic [31:0] data;
        logic        wr;
        logic        trap;
    } rsp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_insn = '0;
    logic [31:0] req_rs1 = '0;
    logic [31:0] req_rs2 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_wr;
    logic        rsp_trap;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr = 1'b0;
    logic [31:0] pcpi_rd = '0;
    logic        pcpi_wait = 1'b0;
    logic        pcpi_ready = 1'b0;

    logic        z_req_valid = 1'b0;
    logic        z_req_ready;
    logic        z_rsp_valid;
    logic [31:0] z_rsp_data;
    logic        z_rsp_wr;
    logic        z_rsp_trap;
    logic        z_pcpi_valid;
    logic [31:0] z_pcpi_insn;
    logic [31:0] z_pcpi_rs1;
    logic [31:0] z_pcpi_rs2;

    int   tests = 0;
    int   fails = 0;
    rsp_t exp_q[$];

    logic [31:0] cur_insn = '0;
    logic [31:0] cur_rs1 = '0;
    logic [31:0] cur_rs2 = '0;

    int          bfm_mode = BFM_NONE;
    int          bfm_lat = 0;
    int          stray_cnt = 0;
    int          stray_seen = 0;
    int          bfm_cnt = 0;
    logic        bfm_busy = 1'b0;
    logic        bfm_dead = 1'b0;
    logic        bfm_in_ready = 1'b0;
    logic [31:0] bfm_result = '0;
    int          wait_pulses = 0;
    int          ready_seen = 0;
    int          valid_in_ready = 0;

    always #5 clk = ~clk;

    pcpi_issuer #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_insn   (req_insn),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_wr     (rsp_wr),
        .rsp_trap   (rsp_trap),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_ready (pcpi_ready)
    );

    pcpi_issuer #(.TIMEOUT(0)) dut_nto (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (z_req_valid),
        .req_ready  (z_req_ready),
        .req_insn   (req_insn),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .rsp_valid  (z_rsp_valid),
        .rsp_ready  (1'b1),
        .rsp_data   (z_rsp_data),
        .rsp_wr     (z_rsp_wr),
        .rsp_trap   (z_rsp_trap),
        .pcpi_valid (z_pcpi_valid),
        .pcpi_insn  (z_pcpi_insn),
        .pcpi_rs1   (z_pcpi_rs1),
        .pcpi_rs2   (z_pcpi_rs2),
        .pcpi_wr    (1'b0),
        .pcpi_rd    (32'd0),
        .pcpi_wait  (1'b0),
        .pcpi_ready (1'b0)
    );

    function automatic logic [31:0] mulModel(input logic [31:0] insn, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] p;
        case (insn[13:12])
            2'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            2'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            2'd2: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
            default: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
        endcase
    endfunction

    // Responder model: updates on the falling edge so the DUT samples settled inputs.
    always @(negedge clk) begin
        if (!resetn) begin
            pcpi_wait = 1'b0; pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = '0;
            bfm_busy = 1'b0; bfm_dead = 1'b0; bfm_in_ready = 1'b0;
        end else if (bfm_in_ready) begin
            pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = '0;
            bfm_in_ready = 1'b0; bfm_busy = 1'b0;
        end else if (stray_cnt != stray_seen) begin
            stray_seen = stray_cnt;
            pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'hDEAD_BEEF; bfm_in_ready = 1'b1;
        end else if (bfm_busy) begin
            if (bfm_dead) begin
                if (!pcpi_valid) begin bfm_busy = 1'b0; bfm_dead = 1'b0; end
            end else begin
                bfm_cnt = bfm_cnt - 1;
                if (bfm_cnt == 0) begin
                    pcpi_wait = 1'b0;
                    if (bfm_mode == BFM_DROP) bfm_dead = 1'b1;
                    else begin
                        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = bfm_result; bfm_in_ready = 1'b1;
                    end
                end
            end
        end else if (pcpi_valid && (bfm_mode != BFM_NONE) && (pcpi_insn[6:0] == PCPI_OPCODE_OP)
                     && (pcpi_insn[31:25] == PCPI_FUNCT7_MULDIV) && !pcpi_insn[14]) begin
            bfm_busy   = 1'b1;
            bfm_result = (bfm_mode == BFM_HOLD) ? 32'h0000_1234 : mulModel(pcpi_insn, pcpi_rs1, pcpi_rs2);
            bfm_cnt    = bfm_lat;
            if (bfm_lat == 0) begin
                pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = bfm_result; bfm_in_ready = 1'b1;
            end else begin
                pcpi_wait = 1'b1;
                wait_pulses = wait_pulses + 1;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (pcpi_ready) begin
            ready_seen = ready_seen + 1;
            if (pcpi_valid) valid_in_ready = valid_in_ready + 1;
        end
    end

    // Monitor: pops the scoreboard on every response handshake and watches the bus operands.
    always @(negedge clk) begin
        rsp_t e;
        if (resetn && rsp_valid && rsp_ready) begin
            tests = tests + 1;
            if (exp_q.size() == 0) begin
                fails = fails + 1;
                $display("[TB] FAIL unexpected_rsp: got data=%h wr=%b trap=%b, expected no response",
                         rsp_data, rsp_wr, rsp_trap);
            end else begin
                e = exp_q.pop_front();
                if (rsp_data !== e.data || rsp_wr !== e.wr || rsp_trap !== e.trap) begin
                    fails = fails + 1;
                    $display("[TB] FAIL rsp: got data=%h wr=%b trap=%b, expected data=%h wr=%b trap=%b",
                             rsp_data, rsp_wr, rsp_trap, e.data, e.wr, e.trap);
                end
            end
        end
        if (resetn && pcpi_valid) begin
            tests = tests + 1;
            if (pcpi_insn !== cur_insn || pcpi_rs1 !== cur_rs1 || pcpi_rs2 !== cur_rs2) begin
                fails = fails + 1;
                $display("[TB] FAIL bus_stable: got %h/%h/%h, expected %h/%h/%h",
                         pcpi_insn, pcpi_rs1, pcpi_rs2, cur_insn, cur_rs1, cur_rs2);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests = tests + 1;
        if (actual !== expected) begin
            fails = fails + 1;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Called one step after a rising edge with the DUT idle; returns one step after handshake edge E0.
    task automatic applyStimulus(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                                 input bit push, input rsp_t exp_rsp);
        checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
        cur_insn = insn; cur_rs1 = rs1; cur_rs2 = rs2;
        req_insn = insn; req_rs1 = rs1; req_rs2 = rs2;
        req_valid = 1'b1;
        if (push) exp_q.push_back(exp_rsp);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Latency is the cycle offset from E0 in which rsp_valid is first seen.
    task automatic waitResponse(output int lat);
        lat = -1;
        if (rsp_valid) lat = 1;
        for (int n = 1; n < 100 && lat < 0; n++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) lat = n + 1;
        end
        if (lat < 0) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("[TB] FAIL rsp_timeout: got no rsp_valid within 100 cycles, expected a response");
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected $finish before 200us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int w0;
        int r0;
        int v0;
        int seen;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_rsp_wr", {31'd0, rsp_wr}, 32'd0);
        checkOutput("rst_rsp_trap", {31'd0, rsp_trap}, 32'd0);
        checkOutput("rst_rsp_data", rsp_data, 32'd0);
        checkOutput("rst_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
        checkOutput("rst_pcpi_insn", pcpi_insn, 32'd0);
        checkOutput("rst_pcpi_rs1", pcpi_rs1, 32'd0);
        checkOutput("rst_pcpi_rs2", pcpi_rs2, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] MUL 7*6 with 3 wait cycles");
        bfm_mode = BFM_MUL; bfm_lat = 3;
        w0 = wait_pulses; r0 = ready_seen; v0 = valid_in_ready;
        applyStimulus(INSN_MUL, 32'd7, 32'd6, 1'b1, '{data: 32'd42, wr: 1'b1, trap: 1'b0});
        waitResponse(lat);
        checkOutput("mul_latency", 32'(lat), 32'd5);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("mul_wait_pulses", 32'(wait_pulses - w0), 32'd1);
        checkOutput("mul_ready_seen", 32'(ready_seen - r0), 32'd1);
        checkOutput("mul_valid_in_ready", 32'(valid_in_ready - v0), 32'd0);

        $display("[TB] MUL 9*9 answered in the first ISSUE cycle");
        bfm_lat = 0;
        applyStimulus(INSN_MUL, 32'd9, 32'd9, 1'b1, '{data: 32'd81, wr: 1'b1, trap: 1'b0});
        waitResponse(lat);
        checkOutput("min_latency", 32'(lat), 32'd2);
        @(posedge clk);
        #1;

        $display("[TB] MULHU all ones");
        bfm_lat = 2;
        applyStimulus(INSN_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
                      '{data: 32'hFFFF_FFFE, wr: 1'b1, trap: 1'b0});
        waitResponse(lat);
        checkOutput("mulhu_latency", 32'(lat), 32'd4);
        @(posedge clk);
        #1;

        $display("[TB] no responder, timeout trap");
        bfm_mode = BFM_NONE;
        applyStimulus(INSN_MUL, 32'd1, 32'd2, 1'b1, '{data: 32'd0, wr: 1'b0, trap: 1'b1});
        waitResponse(lat);
        checkOutput("trap_latency", 32'(lat), 32'd17);
        @(posedge clk);
        #1;

        $display("[TB] wait held 40 cycles then ready");
        bfm_mode = BFM_HOLD; bfm_lat = 40;
        applyStimulus(INSN_MUL, 32'd3, 32'd3, 1'b1, '{data: 32'h0000_1234, wr: 1'b1, trap: 1'b0});
        waitResponse(lat);
        checkOutput("hold_latency", 32'(lat), 32'd42);
        @(posedge clk);
        #1;

        $display("[TB] wait dropped after 3 cycles, no ready");
        bfm_mode = BFM_DROP; bfm_lat = 3;
        applyStimulus(INSN_MUL, 32'd4, 32'd4, 1'b1, '{data: 32'd0, wr: 1'b0, trap: 1'b1});
        waitResponse(lat);
        checkOutput("drop_latency", 32'(lat), 32'd20);
        @(posedge clk);
        #1;

        $display("[TB] response backpressure");
        bfm_mode = BFM_MUL; bfm_lat = 1;
        rsp_ready = 1'b0;
        applyStimulus(INSN_MUL, 32'd7, 32'd6, 1'b1, '{data: 32'd42, wr: 1'b1, trap: 1'b0});
        waitResponse(lat);
        checkOutput("bp_latency", 32'(lat), 32'd3);
        req_insn = INSN_MULHU; req_rs1 = 32'd5; req_rs2 = 32'd5;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            checkOutput("bp_rsp_data", rsp_data, 32'd42);
            checkOutput("bp_rsp_wr", {31'd0, rsp_wr}, 32'd1);
            checkOutput("bp_rsp_trap", {31'd0, rsp_trap}, 32'd0);
            checkOutput("bp_req_ready", {31'd0, req_ready}, 32'd0);
            checkOutput("bp_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("bp_not_accepted", {31'd0, pcpi_valid}, 32'd0);
        checkOutput("bp_pcpi_insn_kept", pcpi_insn, INSN_MUL);

        $display("[TB] stray ready in IDLE");
        bfm_mode = BFM_NONE;
        stray_cnt = stray_cnt + 1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid || !req_ready) seen = seen + 1;
        end
        checkOutput("stray_no_effect", 32'(seen), 32'd0);

        $display("[TB] reset during ISSUE");
        applyStimulus(INSN_MUL, 32'd1, 32'd2, 1'b0, '{data: 32'd0, wr: 1'b0, trap: 1'b0});
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_mid_in_issue", {31'd0, pcpi_valid}, 32'd1);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        checkOutput("rst_mid_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
        checkOutput("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_mid_pcpi_insn", pcpi_insn, 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen = seen + 1;
        end
        checkOutput("rst_mid_no_rsp", 32'(seen), 32'd0);
        bfm_mode = BFM_MUL; bfm_lat = 2;
        applyStimulus(INSN_MUL, 32'd3, 32'd5, 1'b1, '{data: 32'd15, wr: 1'b1, trap: 1'b0});
        waitResponse(lat);
        checkOutput("post_rst_latency", 32'(lat), 32'd4);
        @(posedge clk);
        #1;

        $display("[TB] TIMEOUT=0 instance, 1000 cycles without responder");
        req_insn = INSN_MUL; req_rs1 = 32'd11; req_rs2 = 32'd13;
        z_req_valid = 1'b1;
        @(posedge clk);
        #1;
        z_req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (z_rsp_valid) seen = seen + 1;
        end
        checkOutput("nto_no_rsp", 32'(seen), 32'd0);
        checkOutput("nto_pcpi_valid", {31'd0, z_pcpi_valid}, 32'd1);
        checkOutput("nto_req_ready", {31'd0, z_req_ready}, 32'd0);
        checkOutput("nto_bus", z_pcpi_insn ^ z_pcpi_rs1 ^ z_pcpi_rs2, INSN_MUL ^ 32'd11 ^ 32'd13);
        checkOutput("nto_rsp_regs", z_rsp_data | {31'd0, z_rsp_wr} | {31'd0, z_rsp_trap}, 32'd0);

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
